// File: rtl/tdc_multi_channel.sv
// Multi-channel TDC: per-channel rising-edge timestamp and time-over-threshold capture,
// per-channel event FIFOs, round-robin readout into one hasEvent/clear output register.
//
// state     | meaning
// IDLE      | armed, waiting for a rising edge on the trigger
// WAIT_LOW  | enabled while trigger was already high; wait for it to drop
// MEASURE   | counting time-over-threshold while trigger is high
// PUSH      | write {TS, TOT} into the channel FIFO, or flag overflow
module tdc_multi_channel #(
  parameter int NUM_CH     = 4,
  parameter int TS_WIDTH   = 32,
  parameter int TOT_WIDTH  = 16,
  parameter int FIFO_DEPTH = 4,
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_CH-1:0]    i_enable_channel,
  input  logic [NUM_CH-1:0]    i_trigger,
  input  logic                 i_clear,
  output logic                 o_hasEvent,
  output logic [NUM_CH-1:0]    o_busy,
  output logic [CH_W-1:0]      o_channel,
  output logic [TS_WIDTH-1:0]  o_timestamp,
  output logic [TOT_WIDTH-1:0] o_pulseWidth,
  output logic [NUM_CH-1:0]    o_overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = TS_WIDTH + TOT_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_WAIT_LOW, S_MEASURE, S_PUSH} state_t;

  state_t               state_q [NUM_CH], state_d [NUM_CH];
  logic [NUM_CH-1:0]    trig_prev_q, trig_prev_d;
  logic [TS_WIDTH-1:0]  ts_q, ts_d;
  logic [TS_WIDTH-1:0]  cap_ts_q [NUM_CH], cap_ts_d [NUM_CH];
  logic [TOT_WIDTH-1:0] tot_q [NUM_CH], tot_d [NUM_CH];
  logic [NUM_CH-1:0]    ovf_q, ovf_d;
  logic [EW-1:0]        mem_q [NUM_CH][FIFO_DEPTH], mem_d [NUM_CH][FIFO_DEPTH];
  logic [AW:0]          wr_ptr_q [NUM_CH], wr_ptr_d [NUM_CH];
  logic [AW:0]          rd_ptr_q [NUM_CH], rd_ptr_d [NUM_CH];
  logic                 out_vld_q, out_vld_d;
  logic [CH_W-1:0]      out_ch_q, out_ch_d;
  logic [TS_WIDTH-1:0]  out_ts_q, out_ts_d;
  logic [TOT_WIDTH-1:0] out_tot_q, out_tot_d;
  logic [CH_W-1:0]      last_q, last_d;
  logic [NUM_CH-1:0]    pop;
  logic                 grant_ok;
  logic [CH_W-1:0]      grant;

  // Readout: refill the output register only while it is empty, searching after the last grant.
  always_comb begin
    int cand;
    out_vld_d = out_vld_q;
    out_ch_d  = out_ch_q;
    out_ts_d  = out_ts_q;
    out_tot_d = out_tot_q;
    rd_ptr_d  = rd_ptr_q;
    last_d    = last_q;
    pop       = '0;
    grant_ok  = 1'b0;
    grant     = '0;
    cand      = 0;
    if (out_vld_q) begin
      if (i_clear) out_vld_d = 1'b0;
    end else begin
      for (int i = 1; i <= NUM_CH; i++) begin
        cand = (int'(last_q) + i) % NUM_CH;
        if (!grant_ok && (wr_ptr_q[cand] != rd_ptr_q[cand])) begin
          grant_ok = 1'b1;
          grant    = CH_W'(cand);
        end
      end
      if (grant_ok) begin
        pop[grant]             = 1'b1;
        out_vld_d              = 1'b1;
        out_ch_d               = grant;
        {out_ts_d, out_tot_d}  = mem_q[grant][rd_ptr_q[grant][AW-1:0]];
        rd_ptr_d[grant]        = rd_ptr_q[grant] + (AW+1)'(1);
        last_d                 = grant;
      end
    end
  end

  always_comb begin
    logic full;
    ts_d        = ts_q + TS_WIDTH'(1);
    trig_prev_d = i_trigger;
    state_d     = state_q;
    cap_ts_d    = cap_ts_q;
    tot_d       = tot_q;
    ovf_d       = ovf_q;
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    full        = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      full = (wr_ptr_q[c] == (rd_ptr_q[c] ^ {1'b1, {AW{1'b0}}}));
      if (!i_enable_channel[c]) begin
        state_d[c] = S_IDLE;
        ovf_d[c]   = 1'b0;
      end else begin
        case (state_q[c])
          S_IDLE: begin
            if (i_trigger[c] && !trig_prev_q[c]) begin
              state_d[c]  = S_MEASURE;
              cap_ts_d[c] = ts_q;
              tot_d[c]    = TOT_WIDTH'(1);
            end else if (i_trigger[c]) begin
              state_d[c] = S_WAIT_LOW;
            end
          end
          S_WAIT_LOW: if (!i_trigger[c]) state_d[c] = S_IDLE;
          S_MEASURE: begin
            if (i_trigger[c]) begin
              if (tot_q[c] != {TOT_WIDTH{1'b1}}) tot_d[c] = tot_q[c] + TOT_WIDTH'(1);
            end else begin
              state_d[c] = S_PUSH;
            end
          end
          S_PUSH: begin
            state_d[c] = S_IDLE;
            // a same-cycle pop frees a slot, so full+pop still accepts the write
            if (!full || pop[c]) begin
              mem_d[c][wr_ptr_q[c][AW-1:0]] = {cap_ts_q[c], tot_q[c]};
              wr_ptr_d[c] = wr_ptr_q[c] + (AW+1)'(1);
            end else begin
              ovf_d[c] = 1'b1;
            end
          end
          default: state_d[c] = S_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= '{default: S_IDLE};
      trig_prev_q <= '0;
      ts_q        <= '0;
      cap_ts_q    <= '{default: '0};
      tot_q       <= '{default: '0};
      ovf_q       <= '0;
      mem_q       <= '{default: '0};
      wr_ptr_q    <= '{default: '0};
      rd_ptr_q    <= '{default: '0};
      out_vld_q   <= 1'b0;
      out_ch_q    <= '0;
      out_ts_q    <= '0;
      out_tot_q   <= '0;
      last_q      <= CH_W'(NUM_CH - 1);
    end else begin
      state_q     <= state_d;
      trig_prev_q <= trig_prev_d;
      ts_q        <= ts_d;
      cap_ts_q    <= cap_ts_d;
      tot_q       <= tot_d;
      ovf_q       <= ovf_d;
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      out_vld_q   <= out_vld_d;
      out_ch_q    <= out_ch_d;
      out_ts_q    <= out_ts_d;
      out_tot_q   <= out_tot_d;
      last_q      <= last_d;
    end
  end

  always_comb begin
    o_busy = '0;
    for (int c = 0; c < NUM_CH; c++) o_busy[c] = (state_q[c] != S_IDLE);
  end

  assign o_hasEvent   = out_vld_q;
  assign o_channel    = out_ch_q;
  assign o_timestamp  = out_ts_q;
  assign o_pulseWidth = out_tot_q;
  assign o_overflow   = ovf_q;

endmodule

// File: tb/tb_tdc_multi_channel.sv
// Scoreboard bench for tdc_multi_channel: a default-width instance plus a narrow instance
// (TS_WIDTH=6, TOT_WIDTH=4) for saturation and timestamp wrap.
module tb_tdc_multi_channel;
  typedef struct {
    int      ch;
    longint  ts;
    longint  tot;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sel = 1'b0;
  logic        clr = 1'b0;
  logic [3:0]  en_m = '0, trig_m = '0;
  logic [1:0]  en_s = '0, trig_s = '0;
  logic        m_clear, s_clear;
  logic        m_has, s_has;
  logic [3:0]  m_busy, m_ovf;
  logic [1:0]  s_busy, s_ovf;
  logic [1:0]  m_ch;
  logic [0:0]  s_ch;
  logic [31:0] m_ts;
  logic [5:0]  s_ts;
  logic [15:0] m_tot;
  logic [3:0]  s_tot;
  logic        obs_has;
  logic [63:0] obs_ch, obs_ts, obs_tot;
  logic [31:0] tb_ts;
  ev_t         sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  assign m_clear = clr & ~sel;
  assign s_clear = clr & sel;

  always #5 clk = ~clk;

  // reference timebase: counts edges since reset release
  always @(posedge clk or posedge rst) begin
    if (rst) tb_ts <= '0;
    else     tb_ts <= tb_ts + 32'd1;
  end

  always_comb begin
    if (sel) begin
      obs_has = s_has;
      obs_ch  = 64'(s_ch);
      obs_ts  = 64'(s_ts);
      obs_tot = 64'(s_tot);
    end else begin
      obs_has = m_has;
      obs_ch  = 64'(m_ch);
      obs_ts  = 64'(m_ts);
      obs_tot = 64'(m_tot);
    end
  end

  tdc_multi_channel dut (
    .clk(clk), .reset(rst), .i_enable_channel(en_m), .i_trigger(trig_m), .i_clear(m_clear),
    .o_hasEvent(m_has), .o_busy(m_busy), .o_channel(m_ch), .o_timestamp(m_ts),
    .o_pulseWidth(m_tot), .o_overflow(m_ovf)
  );

  tdc_multi_channel #(.NUM_CH(2), .TS_WIDTH(6), .TOT_WIDTH(4), .FIFO_DEPTH(4)) dut_s (
    .clk(clk), .reset(rst), .i_enable_channel(en_s), .i_trigger(trig_s), .i_clear(s_clear),
    .o_hasEvent(s_has), .o_busy(s_busy), .o_channel(s_ch), .o_timestamp(s_ts),
    .o_pulseWidth(s_tot), .o_overflow(s_ovf)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_trig(input int ch, input logic v);
    if (sel) trig_s[ch] = v;
    else     trig_m[ch] = v;
  endtask

  task automatic expect_ev(input int ch, input longint ts, input longint n);
    ev_t e;
    e.ch = ch;
    if (sel) begin
      e.ts  = ts % 64;
      e.tot = (n > 15) ? 15 : n;
    end else begin
      e.ts  = ts % 64'h1_0000_0000;
      e.tot = (n > 65535) ? 65535 : n;
    end
    sb.push_back(e);
  endtask

  // trigger high for n sampled edges; returns at the negedge where it is driven low
  task automatic pulse(input int ch, input int n, input bit exp);
    longint t0;
    set_trig(ch, 1'b1);
    t0 = longint'(tb_ts);
    repeat (n) @(negedge clk);
    set_trig(ch, 1'b0);
    if (exp) expect_ev(ch, t0, n);
  endtask

  task automatic pulse2(input int ch_a, input int ch_b, input int n);
    longint t0;
    set_trig(ch_a, 1'b1);
    set_trig(ch_b, 1'b1);
    t0 = longint'(tb_ts);
    repeat (n) @(negedge clk);
    set_trig(ch_a, 1'b0);
    set_trig(ch_b, 1'b0);
    expect_ev(ch_a, t0, n);
    expect_ev(ch_b, t0, n);
  endtask

  task automatic drain_one();
    int  waited;
    ev_t e;
    waited = 0;
    while (!obs_has && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!obs_has) begin
      check_val("event_timeout", 64'(obs_has), 64'd1);
      return;
    end
    if (sb.size() == 0) begin
      check_val("unexpected_event", 64'(obs_has), 64'd0);
    end else begin
      e = sb.pop_front();
      check_val("channel", obs_ch, 64'(e.ch));
      check_val("timestamp", obs_ts, 64'(e.ts));
      check_val("pulse_width", obs_tot, 64'(e.tot));
    end
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check_val("cleared", 64'(obs_has), 64'd0);
  endtask

  task automatic wait_ts(input int v, input int bits);
    int g;
    g = 0;
    while ((tb_ts & ((32'd1 << bits) - 32'd1)) != 32'(v) && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (g >= 200) check_val("ts_wait_timeout", 64'(tb_ts), 64'(v));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    en_m = 4'hF;
    en_s = 2'b11;
    repeat (3) @(negedge clk);
    check_val("rst_has", 64'(m_has), 64'd0);
    check_val("rst_busy", 64'(m_busy), 64'd0);
    check_val("rst_ovf", 64'(m_ovf), 64'd0);
    check_val("rst_ts", 64'(m_ts), 64'd0);
    rst = 1'b0;

    // 1: single event at TS=10, 5 edges high, plus load latency
    wait_ts(10, 32);
    pulse(0, 5, 1'b1);
    repeat (2) @(negedge clk);
    check_val("lat_before_load", 64'(m_has), 64'd0);
    @(negedge clk);
    check_val("lat_load", 64'(m_has), 64'd1);
    drain_one();

    // 2: same-cycle pushes on ch1/ch2, then round-robin resumes at ch3
    pulse2(1, 2, 3);
    repeat (4) @(negedge clk);
    drain_one();
    drain_one();
    pulse2(3, 0, 2);
    repeat (4) @(negedge clk);
    drain_one();
    drain_one();

    // 3: output register held by ch1, five ch0 events -> fifth dropped
    pulse(1, 2, 1'b1);
    repeat (4) @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      pulse(0, 2, (k < 4));
      repeat (3) @(negedge clk);
    end
    check_val("ovf_set", 64'(m_ovf[0]), 64'd1);
    en_m[0] = 1'b0;
    @(negedge clk);
    check_val("ovf_cleared", 64'(m_ovf[0]), 64'd0);
    en_m[0] = 1'b1;
    for (int k = 0; k < 5; k++) drain_one();

    // 4: narrow instance, TOT saturation and timestamp wrap
    sel = 1'b1;
    wait_ts(63, 6);
    pulse(0, 20, 1'b1);
    repeat (4) @(negedge clk);
    drain_one();
    wait_ts(0, 6);
    pulse(1, 2, 1'b1);
    repeat (4) @(negedge clk);
    drain_one();
    sel = 1'b0;

    // 5: enable while high -> no event; disable during MEASURE -> discarded
    en_m[2] = 1'b0;
    @(negedge clk);
    trig_m[2] = 1'b1;
    repeat (2) @(negedge clk);
    en_m[2] = 1'b1;
    repeat (2) @(negedge clk);
    check_val("wait_low_busy", 64'(m_busy[2]), 64'd1);
    trig_m[2] = 1'b0;
    repeat (2) @(negedge clk);
    check_val("wait_low_idle", 64'(m_busy[2]), 64'd0);
    repeat (5) @(negedge clk);
    check_val("no_event_wait_low", 64'(m_has), 64'd0);
    trig_m[2] = 1'b1;
    repeat (2) @(negedge clk);
    check_val("measure_busy", 64'(m_busy[2]), 64'd1);
    en_m[2] = 1'b0;
    @(negedge clk);
    check_val("disable_busy", 64'(m_busy[2]), 64'd0);
    trig_m[2] = 1'b0;
    en_m[2] = 1'b1;
    repeat (6) @(negedge clk);
    check_val("no_event_disable", 64'(m_has), 64'd0);

    // 6: asynchronous reset mid-MEASURE with events queued
    pulse(0, 2, 1'b1);
    repeat (3) @(negedge clk);
    pulse(1, 2, 1'b1);
    repeat (3) @(negedge clk);
    trig_m[3] = 1'b1;
    repeat (2) @(negedge clk);
    check_val("pre_rst_busy", 64'(m_busy[3]), 64'd1);
    check_val("pre_rst_has", 64'(m_has), 64'd1);
    #2 rst = 1'b1;
    #1;
    check_val("arst_has", 64'(m_has), 64'd0);
    check_val("arst_busy", 64'(m_busy), 64'd0);
    check_val("arst_ch", 64'(m_ch), 64'd0);
    check_val("arst_ts", 64'(m_ts), 64'd0);
    check_val("arst_tot", 64'(m_tot), 64'd0);
    check_val("arst_ovf", 64'(m_ovf), 64'd0);
    sb.delete();
    trig_m = '0;
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check_val("post_rst_has", 64'(m_has), 64'd0);
    check_val("post_rst_busy", 64'(m_busy), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
